// File: rtl/mpf_vtp_pt_fim_bridge_if.sv
// Walker/host-channel bundle for the VTP page-table FIM bridge.
// slave: bridge view; master: walker plus host-channel view.
interface mpf_vtp_pt_fim_bridge_if #(
  parameter int ADDR_WIDTH    = 42,
  parameter int DATA_WIDTH    = 512,
  parameter int TAG_WIDTH     = 16,
  parameter int WR_DATA_WIDTH = 64,
  parameter int MAX_RD_OUT    = 4,
  parameter int MAX_WR_OUT    = 4
);
  localparam int IDX_W = $clog2(MAX_RD_OUT);
  localparam int CNT_W = IDX_W + 1;

  logic                     pt_rd_en;
  logic [ADDR_WIDTH-1:0]    pt_rd_addr;
  logic [TAG_WIDTH-1:0]     pt_rd_tag;
  logic                     pt_rd_rdy;
  logic                     pt_rd_data_en;
  logic [DATA_WIDTH-1:0]    pt_rd_data;
  logic [TAG_WIDTH-1:0]     pt_rd_rsp_tag;

  logic                     pt_wr_en;
  logic [ADDR_WIDTH-1:0]    pt_wr_addr;
  logic [WR_DATA_WIDTH-1:0] pt_wr_data;
  logic                     pt_wr_rdy;

  logic                     mem_rd_valid;
  logic [ADDR_WIDTH-1:0]    mem_rd_addr;
  logic [IDX_W-1:0]         mem_rd_idx;
  logic                     mem_rd_almfull;
  logic                     mem_rsp_valid;
  logic [IDX_W-1:0]         mem_rsp_idx;
  logic [DATA_WIDTH-1:0]    mem_rsp_data;

  logic                     mem_wr_valid;
  logic [ADDR_WIDTH-1:0]    mem_wr_addr;
  logic [DATA_WIDTH-1:0]    mem_wr_data;
  logic                     mem_wr_almfull;
  logic                     mem_wr_ack;

  logic [CNT_W-1:0]         rd_busy_cnt;
  logic                     err_bad_rsp;

  modport slave (
    input  pt_rd_en, pt_rd_addr, pt_rd_tag,
    output pt_rd_rdy, pt_rd_data_en, pt_rd_data, pt_rd_rsp_tag,
    input  pt_wr_en, pt_wr_addr, pt_wr_data,
    output pt_wr_rdy,
    output mem_rd_valid, mem_rd_addr, mem_rd_idx,
    input  mem_rd_almfull, mem_rsp_valid, mem_rsp_idx, mem_rsp_data,
    output mem_wr_valid, mem_wr_addr, mem_wr_data,
    input  mem_wr_almfull, mem_wr_ack,
    output rd_busy_cnt, err_bad_rsp
  );

  modport master (
    output pt_rd_en, pt_rd_addr, pt_rd_tag,
    input  pt_rd_rdy, pt_rd_data_en, pt_rd_data, pt_rd_rsp_tag,
    output pt_wr_en, pt_wr_addr, pt_wr_data,
    input  pt_wr_rdy,
    input  mem_rd_valid, mem_rd_addr, mem_rd_idx,
    output mem_rd_almfull, mem_rsp_valid, mem_rsp_idx, mem_rsp_data,
    input  mem_wr_valid, mem_wr_addr, mem_wr_data,
    output mem_wr_almfull, mem_wr_ack,
    input  rd_busy_cnt, err_bad_rsp
  );
endinterface

// File: rtl/mpf_vtp_pt_fim_bridge.sv
// FIM-side endpoint of the VTP page-table walker host port.
// Reads remapped through a local tag table; responses may be out of order.
module mpf_vtp_pt_fim_bridge #(
  parameter int ADDR_WIDTH    = 42,
  parameter int DATA_WIDTH    = 512,
  parameter int TAG_WIDTH     = 16,
  parameter int WR_DATA_WIDTH = 64,
  parameter int MAX_RD_OUT    = 4,
  parameter int MAX_WR_OUT    = 4
) (
  input logic clk,
  input logic reset,
  mpf_vtp_pt_fim_bridge_if.slave bus
);
  localparam int IDX_W  = $clog2(MAX_RD_OUT);
  localparam int CNT_W  = IDX_W + 1;
  localparam int WCNT_W = $clog2(MAX_WR_OUT + 1);

  logic [MAX_RD_OUT-1:0]  free;
  logic [TAG_WIDTH-1:0]   tag_tab [MAX_RD_OUT];
  logic [IDX_W-1:0]       alloc_idx;
  logic                   rd_rdy;
  logic                   rd_acc;
  logic                   rsp_ok;
  logic                   rsp_bad;

  logic                   rd_valid_q;
  logic [ADDR_WIDTH-1:0]  rd_addr_q;
  logic [IDX_W-1:0]       rd_idx_q;

  logic                   den_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic [IDX_W-1:0]       rel_idx_q;
  logic [CNT_W-1:0]       busy_q;

  logic [WCNT_W-1:0]      wr_cnt;
  logic                   wr_rdy;
  logic                   wr_acc;
  logic                   ack_ok;
  logic                   ack_bad;
  logic                   wr_valid_q;
  logic [ADDR_WIDTH-1:0]  wr_addr_q;
  logic [DATA_WIDTH-1:0]  wr_data_q;
  logic                   err_q;

  // Pick the lowest free tag-table slot from the start-of-cycle vector.
  always_comb begin
    alloc_idx = '0;
    for (int i = MAX_RD_OUT - 1; i >= 0; i--) begin
      if (free[i]) alloc_idx = IDX_W'(i);
    end
  end

  // A slot whose response is already in the output stage is still
  // marked busy, so it must be excluded to catch duplicate responses.
  always_comb begin
    rd_rdy  = (|free) & ~bus.mem_rd_almfull & ~reset;
    rd_acc  = bus.pt_rd_en & rd_rdy;
    rsp_ok  = bus.mem_rsp_valid
            & ~free[bus.mem_rsp_idx]
            & ~(den_q & (rel_idx_q == bus.mem_rsp_idx));
    rsp_bad = bus.mem_rsp_valid & ~rsp_ok;
  end

  // Write-side acceptance and ack qualification.
  always_comb begin
    wr_rdy  = (wr_cnt < WCNT_W'(MAX_WR_OUT))
            & ~bus.mem_wr_almfull & ~reset;
    wr_acc  = bus.pt_wr_en & wr_rdy;
    ack_ok  = bus.mem_wr_ack & (wr_cnt != '0);
    ack_bad = bus.mem_wr_ack & (wr_cnt == '0);
  end

  // Free vector: release one cycle after data_en, allocate on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      free <= '1;
    end else begin
      if (den_q)  free[rel_idx_q] <= 1'b1;
      if (rd_acc) free[alloc_idx] <= 1'b0;
    end
  end

  // Tag table holds the walker tag for each allocated slot.
  always_ff @(posedge clk) begin
    if (rd_acc) tag_tab[alloc_idx] <= bus.pt_rd_tag;
  end

  // Registered host read request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_idx_q   <= '0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        rd_addr_q <= bus.pt_rd_addr;
        rd_idx_q  <= alloc_idx;
      end
    end
  end

  // Registered read response back to the walker.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      den_q     <= 1'b0;
      data_q    <= '0;
      tag_q     <= '0;
      rel_idx_q <= '0;
    end else begin
      den_q <= rsp_ok;
      if (rsp_ok) begin
        data_q    <= bus.mem_rsp_data;
        tag_q     <= tag_tab[bus.mem_rsp_idx];
        rel_idx_q <= bus.mem_rsp_idx;
      end
    end
  end

  // Reads in flight track the free vector: +accept, -release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_q + CNT_W'(rd_acc) - CNT_W'(den_q);
    end
  end

  // Outstanding write counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt <= '0;
    end else begin
      wr_cnt <= wr_cnt + WCNT_W'(wr_acc) - WCNT_W'(ack_ok);
    end
  end

  // Registered host write request, message zero-extended to a line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      wr_valid_q <= wr_acc;
      if (wr_acc) begin
        wr_addr_q <= bus.pt_wr_addr;
        wr_data_q <= DATA_WIDTH'(bus.pt_wr_data);
      end
    end
  end

  // Sticky protocol error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (rsp_bad | ack_bad) begin
      err_q <= 1'b1;
    end
  end

  assign bus.pt_rd_rdy     = rd_rdy;
  assign bus.pt_rd_data_en = den_q;
  assign bus.pt_rd_data    = data_q;
  assign bus.pt_rd_rsp_tag = tag_q;
  assign bus.pt_wr_rdy     = wr_rdy;
  assign bus.mem_rd_valid  = rd_valid_q;
  assign bus.mem_rd_addr   = rd_addr_q;
  assign bus.mem_rd_idx    = rd_idx_q;
  assign bus.mem_wr_valid  = wr_valid_q;
  assign bus.mem_wr_addr   = wr_addr_q;
  assign bus.mem_wr_data   = wr_data_q;
  assign bus.rd_busy_cnt   = busy_q;
  assign bus.err_bad_rsp   = err_q;
endmodule

// File: tb/tb_mpf_vtp_pt_fim_bridge.sv
// Bench for mpf_vtp_pt_fim_bridge: directed cases plus random traffic
// checked against a slot-level behavioural model.
module tb_mpf_vtp_pt_fim_bridge;
  localparam int AW = 42;
  localparam int DW = 512;
  localparam int TW = 16;
  localparam int WW = 64;
  localparam int NR = 4;
  localparam int NW = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mpf_vtp_pt_fim_bridge_if #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW),
    .WR_DATA_WIDTH(WW), .MAX_RD_OUT(NR), .MAX_WR_OUT(NW)
  ) bif ();

  mpf_vtp_pt_fim_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW),
    .WR_DATA_WIDTH(WW), .MAX_RD_OUT(NR), .MAX_WR_OUT(NW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bif.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  bit            m_busy [NR];
  logic [TW-1:0] m_tag  [NR];
  bit            m_rel_v;
  int            m_rel_idx;
  int            m_wcnt;
  bit            m_err;
  bit            e_den;
  logic [DW-1:0] e_data;
  logic [TW-1:0] e_tag;
  bit            e_rv;
  logic [AW-1:0] e_raddr;
  int            e_ridx;
  bit            e_wv;
  logic [AW-1:0] e_waddr;
  logic [DW-1:0] e_wdata;
  int            hq [$];

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < NR; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic int busy_count();
    int c = 0;
    for (int i = 0; i < NR; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic bit exp_rd_rdy();
    return (lowest_free() >= 0) && !bif.mem_rd_almfull;
  endfunction

  function automatic bit exp_wr_rdy();
    return (m_wcnt < NW) && !bif.mem_wr_almfull;
  endfunction

  function automatic logic [DW-1:0] rdata();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_busy[i] = 0;
      m_tag[i]  = '0;
    end
    m_rel_v = 0; m_rel_idx = 0; m_wcnt = 0; m_err = 0;
    e_den = 0; e_data = '0; e_tag = '0;
    e_rv = 0; e_raddr = '0; e_ridx = 0;
    e_wv = 0; e_waddr = '0; e_wdata = '0;
    hq.delete();
  endtask

  // One clock edge of the specified behaviour, using current inputs.
  task automatic model_update();
    int  a    = lowest_free();
    bit  acc  = bif.pt_rd_en && exp_rd_rdy();
    bit  wacc = bif.pt_wr_en && exp_wr_rdy();
    bit  good = 0;
    int  ri   = int'(bif.mem_rsp_idx);
    if (bif.mem_rsp_valid) begin
      good = m_busy[ri] && !(m_rel_v && m_rel_idx == ri);
      if (!good) m_err = 1;
    end
    e_den = good;
    if (good) begin
      e_tag  = m_tag[ri];
      e_data = bif.mem_rsp_data;
    end
    if (m_rel_v) m_busy[m_rel_idx] = 0;
    m_rel_v   = good;
    m_rel_idx = ri;
    e_rv = acc;
    if (acc) begin
      m_busy[a] = 1;
      m_tag[a]  = bif.pt_rd_tag;
      e_raddr   = bif.pt_rd_addr;
      e_ridx    = a;
      hq.push_back(a);
    end
    if (bif.mem_wr_ack) begin
      if (m_wcnt == 0) m_err = 1;
      else m_wcnt--;
    end
    if (wacc) m_wcnt++;
    e_wv = wacc;
    if (wacc) begin
      e_waddr = bif.pt_wr_addr;
      e_wdata = '0;
      e_wdata[WW-1:0] = bif.pt_wr_data;
    end
  endtask

  task automatic compare_all();
    chk("rd_rdy", bif.pt_rd_rdy, exp_rd_rdy());
    chk("wr_rdy", bif.pt_wr_rdy, exp_wr_rdy());
    chk("rd_data_en", bif.pt_rd_data_en, e_den);
    if (e_den) begin
      chk("rsp_tag", bif.pt_rd_rsp_tag, e_tag);
      chk("rd_data", bif.pt_rd_data, e_data);
    end
    chk("mem_rd_valid", bif.mem_rd_valid, e_rv);
    if (e_rv) begin
      chk("mem_rd_addr", bif.mem_rd_addr, e_raddr);
      chk("mem_rd_idx", bif.mem_rd_idx, e_ridx);
    end
    chk("mem_wr_valid", bif.mem_wr_valid, e_wv);
    if (e_wv) begin
      chk("mem_wr_addr", bif.mem_wr_addr, e_waddr);
      chk("mem_wr_data", bif.mem_wr_data, e_wdata);
    end
    chk("rd_busy_cnt", bif.rd_busy_cnt, busy_count());
    chk("err_bad_rsp", bif.err_bad_rsp, m_err);
  endtask

  task automatic idle();
    bif.pt_rd_en = 0; bif.pt_rd_addr = '0; bif.pt_rd_tag = '0;
    bif.pt_wr_en = 0; bif.pt_wr_addr = '0; bif.pt_wr_data = '0;
    bif.mem_rd_almfull = 0; bif.mem_rsp_valid = 0;
    bif.mem_rsp_idx = '0; bif.mem_rsp_data = '0;
    bif.mem_wr_almfull = 0; bif.mem_wr_ack = 0;
  endtask

  task automatic step();
    #1 compare_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    reset = 0;
  endtask

  task automatic set_rsp(input int idx, input logic [DW-1:0] d);
    int q [$];
    bif.mem_rsp_valid = 1;
    bif.mem_rsp_idx   = IW'(idx);
    bif.mem_rsp_data  = d;
    q = hq.find_first_index(x) with (x == idx);
    if (q.size() > 0) hq.delete(q[0]);
  endtask

  task automatic rd_req(input int addr, input int tag);
    bif.pt_rd_en   = 1;
    bif.pt_rd_addr = AW'(addr);
    bif.pt_rd_tag  = TW'(tag);
  endtask

  initial begin
    logic [DW-1:0] d;
    int idxs [3];
    int tags [3];
    reset = 1;
    idle();
    model_reset();
    @(negedge clk);
    do_reset();

    // reset state
    step();
    chk("rst_busy", bif.rd_busy_cnt, 0);
    chk("rst_err", bif.err_bad_rsp, 0);
    chk("rst_rd_rdy", bif.pt_rd_rdy, 1);
    chk("rst_wr_rdy", bif.pt_wr_rdy, 1);

    // single read
    rd_req('h100, 'h5A);
    step();
    idle();
    chk("t1_rd_valid", bif.mem_rd_valid, 1);
    chk("t1_rd_idx", bif.mem_rd_idx, 0);
    chk("t1_rd_addr", bif.mem_rd_addr, 'h100);
    step();
    d = rdata();
    set_rsp(0, d);
    step();
    idle();
    chk("t1_den", bif.pt_rd_data_en, 1);
    chk("t1_tag", bif.pt_rd_rsp_tag, 'h5A);
    chk("t1_data", bif.pt_rd_data, d);
    step();
    chk("t1_den_pulse", bif.pt_rd_data_en, 0);
    step();

    // fill the table
    for (int t = 1; t <= 4; t++) begin
      rd_req('h200 + t, t);
      step();
    end
    idle();
    #1;
    chk("t2_full_rdy", bif.pt_rd_rdy, 0);
    chk("t2_busy4", bif.rd_busy_cnt, 4);
    rd_req('h2FF, 9);
    step();
    idle();
    set_rsp(2, rdata());
    step();
    idle();
    #1;
    chk("t2_den", bif.pt_rd_data_en, 1);
    chk("t2_tag3", bif.pt_rd_rsp_tag, 3);
    chk("t2_rdy_same", bif.pt_rd_rdy, 0);
    step();
    chk("t2_rdy_next", bif.pt_rd_rdy, 1);
    rd_req('h300, 7);
    step();
    idle();
    chk("t2_realloc_idx", bif.mem_rd_idx, 2);
    step();

    // out-of-order responses
    idxs = '{3, 0, 1};
    tags = '{4, 1, 2};
    for (int k = 0; k < 3; k++) begin
      set_rsp(idxs[k], rdata());
      step();
      idle();
      chk("t3_den", bif.pt_rd_data_en, 1);
      chk("t3_tag", bif.pt_rd_rsp_tag, tags[k]);
    end
    step();
    set_rsp(2, rdata());
    step();
    idle();
    chk("t3_tag7", bif.pt_rd_rsp_tag, 7);
    step();
    step();

    // writes
    for (int k = 0; k < 4; k++) begin
      bif.pt_wr_en   = 1;
      bif.pt_wr_addr = AW'('h400 + k);
      bif.pt_wr_data = 64'hFFFF_FFFF_FFFF_FFF0 | 64'(k);
      step();
      idle();
      if (k == 0) begin
        d = bif.mem_wr_data;
        chk("wr_upper0", d[DW-1:WW], '0);
        chk("wr_lower", d[WW-1:0], 64'hFFFF_FFFF_FFFF_FFF0);
      end
    end
    #1 chk("wr_full_rdy", bif.pt_wr_rdy, 0);
    bif.mem_wr_ack = 1;
    step();
    idle();
    #1 chk("wr_ack_rdy", bif.pt_wr_rdy, 1);
    bif.mem_wr_ack = 1;
    bif.pt_wr_en   = 1;
    bif.pt_wr_data = 64'h1234;
    step();
    idle();
    #1 chk("wr_net0_rdy", bif.pt_wr_rdy, 1);
    bif.pt_wr_en   = 1;
    bif.pt_wr_data = 64'h5678;
    step();
    idle();
    #1 chk("wr_refull_rdy", bif.pt_wr_rdy, 0);
    for (int k = 0; k < 4; k++) begin
      bif.mem_wr_ack = 1;
      step();
    end
    idle();
    step();

    // almost-full blocks reads
    bif.mem_rd_almfull = 1;
    rd_req('h500, 3);
    #1 chk("af_rdy", bif.pt_rd_rdy, 0);
    step();
    idle();
    chk("af_no_req", bif.mem_rd_valid, 0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      bif.pt_rd_en   = ($urandom_range(0, 2) != 0);
      bif.pt_rd_addr = AW'({$urandom, $urandom});
      bif.pt_rd_tag  = TW'($urandom);
      bif.mem_rd_almfull = ($urandom_range(0, 7) == 0);
      bif.mem_rsp_valid  = 0;
      bif.mem_rsp_idx    = IW'($urandom);
      if (hq.size() > 0 && $urandom_range(0, 2) == 0) begin
        set_rsp(hq[$urandom_range(0, hq.size() - 1)], rdata());
      end
      bif.pt_wr_en   = ($urandom_range(0, 1) != 0);
      bif.pt_wr_addr = AW'({$urandom, $urandom});
      bif.pt_wr_data = {$urandom, $urandom};
      bif.mem_wr_almfull = ($urandom_range(0, 7) == 0);
      bif.mem_wr_ack = (m_wcnt > 0) && ($urandom_range(0, 2) == 0);
      step();
    end

    // drain
    for (int c = 0; c < 100; c++) begin
      idle();
      if (hq.size() > 0) set_rsp(hq[0], rdata());
      bif.mem_wr_ack = (m_wcnt > 0);
      step();
    end
    idle();
    step();
    step();
    chk("drain_busy", bif.rd_busy_cnt, 0);

    // response to a free slot
    set_rsp(1, rdata());
    step();
    idle();
    chk("bad_den", bif.pt_rd_data_en, 0);
    chk("bad_err", bif.err_bad_rsp, 1);
    step();
    step();
    step();
    chk("bad_err_sticky", bif.err_bad_rsp, 1);

    // reset with reads in flight, then a late response
    rd_req('h600, 'h11);
    step();
    rd_req('h601, 'h12);
    step();
    idle();
    step();
    chk("pre_rst_busy", bif.rd_busy_cnt, 2);
    do_reset();
    chk("post_rst_busy", bif.rd_busy_cnt, 0);
    chk("post_rst_err", bif.err_bad_rsp, 0);
    step();
    bif.mem_rsp_valid = 1;
    bif.mem_rsp_idx   = '0;
    bif.mem_rsp_data  = rdata();
    step();
    idle();
    chk("late_den", bif.pt_rd_data_en, 0);
    chk("late_err", bif.err_bad_rsp, 1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
